collision_scanner: RTL
======================

COLLISION_SCANNER -- requirements
Module: collision_scanner

Interface
REQ-001 Parameter NUM_CARS, default 8: number of car slots in the position table; legal range 2..16.
REQ-002 Parameter COORD_W, default 10: width of each X/Y coordinate in pixels.
REQ-003 Parameter CAR_LEN, default 60: car footprint long side, in pixels.
REQ-004 Parameter CAR_WID, default 30: car footprint short side, in pixels.
REQ-005 Parameters IDX_W = clog2(NUM_CARS) and CNT_W = clog2(NUM_CARS*(NUM_CARS-1)/2+1) are derived, not set.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  in  1  reset, asynchronous and active-low.
REQ-008 wr_en  in  1  write one table slot this cycle.
REQ-009 wr_idx  in  IDX_W  slot to write; values >= NUM_CARS are ignored.
REQ-010 wr_x, wr_y  in  COORD_W each  top-left corner of the car.
REQ-011 wr_orient  in  2  orientation; bit0=0 is horizontal (CAR_LEN wide, CAR_WID tall), bit0=1 is vertical (CAR_WID wide, CAR_LEN tall).
REQ-012 wr_active  in  1  slot occupied; inactive slots never collide.
REQ-013 start  in  1  request one full pairwise scan.
REQ-014 busy  out  1  scan in progress.
REQ-015 done  out  1  one-cycle pulse when results update.
REQ-016 collision  out  1  at least one colliding pair in the last scan.
REQ-017 hit_a, hit_b  out  IDX_W each  lowest-ordered colliding pair (i<j) of the last scan.
REQ-018 hit_count  out  CNT_W  number of colliding pairs in the last scan.
REQ-019 dirty  out  1  a table write landed during the last scan.

Function
REQ-020 The table SHALL hold per slot {x, y, orient, active}; a write updates the slot at the clock edge and is visible to the scan from the next cycle.
REQ-021 The FSM SHALL have three states: IDLE, SCAN and REPORT.
REQ-022 IDLE->SCAN when start=1 at the edge; pair pointers SHALL load (i=0, j=1); start in SCAN or REPORT SHALL be ignored.
REQ-023 SCAN SHALL evaluate one pair per cycle in order (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1), P=N(N-1)/2 cycles total.
REQ-024 SCAN->REPORT on the edge after pair (N-2,N-1); REPORT->IDLE unconditionally after one cycle.
REQ-025 busy SHALL be 1 in SCAN and REPORT; done SHALL be 1 only in REPORT.
REQ-026 If start is sampled at edge k, done SHALL be high in cycle k+P+1.
REQ-027 A pair collides iff both are active and the footprints overlap strictly: ax < bx+bw, bx < ax+aw, ay < by+bh, by < ay+ah; edge-touching is not a collision.
REQ-028 Coordinate sums SHALL be computed in COORD_W+1 bits, with no modulo wrap.
REQ-029 Any two orientations SHALL be checked, including same-orientation pairs.
REQ-030 Scan accumulators SHALL clear at IDLE->SCAN; collision, hit_a, hit_b, hit_count and dirty SHALL update only on the edge entering REPORT and hold until the next REPORT.
REQ-031 hit_a/hit_b SHALL capture the first colliding pair in scan order; they are 0/0 when collision=0.
REQ-032 hit_count SHALL saturate at its maximum.
REQ-033 A wr_en with a valid index in SCAN SHALL be accepted and SHALL set dirty for that scan; the pairs already evaluated are not redone.
REQ-034 A write and a pair read of the same slot in one cycle SHALL use the old value.

Reset
REQ-035 On rst_n=0, immediately and regardless of clk: state=IDLE; busy, done, collision, dirty=0; hit_a, hit_b, hit_count=0; all slots x=y=0, orient=0, active=0.
REQ-036 Reset in mid-scan SHALL abort the scan with no done pulse; the first scan after reset reports no collision.

Verification
REQ-037 Overlap: slot0 (100,100,o=0), slot1 (130,110,o=1), both active; start -> done at start+29 cycles, collision=1, hit=(0,1), hit_count=1.
REQ-038 Touching: slot0 (100,100,o=0), slot1 (160,100,o=0) -> collision=0, hit_count=0, hit=(0,0).
REQ-039 No wrap: slot2 (1000,0,o=0), slot3 (5,0,o=0) -> collision=0; then move slot3 to (990,10,o=1) and rescan -> collision=1, hit=(2,3).
REQ-040 Inactive and count: three mutually overlapping cars at slots 4, 5 and 6, with slot5 inactive -> hit_count=1, hit=(4,6); make slot5 active -> hit_count=3, hit=(4,5).
REQ-041 Protocol: start held high during a scan gives exactly one done per IDLE entry; a write in SCAN gives dirty=1; rst_n low mid-scan gives busy=0 at once and no done.

Source files
------------

// File: rtl/collision_scanner.sv
// ---------------------------------------------------------------------------
// collision_scanner
//
// Holds a small table of car footprints (top-left corner, orientation,
// occupancy) and, on request, scans every unordered pair of slots once, one
// pair per clock. The scan produces a collision flag, the first colliding
// pair in scan order, a saturating count of colliding pairs and a flag that
// says whether the table was written while the scan was running.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   wr_en      in   write one table slot this cycle
//   wr_idx     in   slot to write (indices >= NUM_CARS are dropped)
//   wr_x/wr_y  in   top-left corner of the car
//   wr_orient  in   bit0: 0 = horizontal (CAR_LEN x CAR_WID), 1 = vertical
//   wr_active  in   slot occupied
//   start      in   request one full pairwise scan (honoured only in IDLE)
//   busy       out  scan or report in progress
//   done       out  one-cycle pulse when the results below update
//   collision  out  at least one colliding pair in the last scan
//   hit_a/b    out  first colliding pair (a < b) of the last scan, 0/0 if none
//   hit_count  out  number of colliding pairs in the last scan (saturating)
//   dirty      out  a table write landed during the last scan
// ---------------------------------------------------------------------------
module collision_scanner #(
    parameter  int NUM_CARS = 8,
    parameter  int COORD_W  = 10,
    parameter  int CAR_LEN  = 60,
    parameter  int CAR_WID  = 30,
    localparam int IDX_W    = $clog2(NUM_CARS),
    localparam int CNT_W    = $clog2(NUM_CARS * (NUM_CARS - 1) / 2 + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   wr_idx,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [1:0]         wr_orient,
    input  logic               wr_active,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               collision,
    output logic [IDX_W-1:0]   hit_a,
    output logic [IDX_W-1:0]   hit_b,
    output logic [CNT_W-1:0]   hit_count,
    output logic               dirty
);

    localparam logic [COORD_W:0] L_LEN = CAR_LEN[COORD_W:0];
    localparam logic [COORD_W:0] L_WID = CAR_WID[COORD_W:0];
    localparam logic [IDX_W-1:0] I_LAST_I = IDX_W'(NUM_CARS - 2);
    localparam logic [IDX_W-1:0] I_LAST_J = IDX_W'(NUM_CARS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_REPORT
    } state_t;

    // Position table
    logic [COORD_W-1:0] r_x      [NUM_CARS];
    logic [COORD_W-1:0] r_y      [NUM_CARS];
    logic [1:0]         r_orient [NUM_CARS];
    logic               r_active [NUM_CARS];

    // Scan control and accumulators
    state_t             r_state;
    logic [IDX_W-1:0]   r_i;
    logic [IDX_W-1:0]   r_j;
    logic               r_acc_found;
    logic [IDX_W-1:0]   r_acc_a;
    logic [IDX_W-1:0]   r_acc_b;
    logic [CNT_W-1:0]   r_acc_cnt;
    logic               r_acc_dirty;

    // Registered outputs
    logic               r_busy;
    logic               r_done;
    logic               r_collision;
    logic [IDX_W-1:0]   r_hit_a;
    logic [IDX_W-1:0]   r_hit_b;
    logic [CNT_W-1:0]   r_hit_count;
    logic               r_dirty;

    logic               w_wr_ok;
    logic [COORD_W:0]   w_ax, w_ay, w_aw, w_ah;
    logic [COORD_W:0]   w_bx, w_by, w_bw, w_bh;
    logic               w_hit;
    logic               w_last;
    logic               w_found_nxt;
    logic [IDX_W-1:0]   w_a_nxt;
    logic [IDX_W-1:0]   w_b_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_dirty_nxt;

    assign w_wr_ok = wr_en && (32'(wr_idx) < NUM_CARS);
    assign w_last  = (r_i == I_LAST_I) && (r_j == I_LAST_J);

    // Pair comparison. Operands are zero-extended by one bit so the corner
    // plus size sums cannot wrap near the top of the coordinate range.
    // The table is read before this edge's write lands, so a same-cycle
    // write to a slot under evaluation is seen only by later pairs.
    always_comb begin
        w_ax = {1'b0, r_x[r_i]};
        w_ay = {1'b0, r_y[r_i]};
        w_bx = {1'b0, r_x[r_j]};
        w_by = {1'b0, r_y[r_j]};
        w_aw = r_orient[r_i][0] ? L_WID : L_LEN;
        w_ah = r_orient[r_i][0] ? L_LEN : L_WID;
        w_bw = r_orient[r_j][0] ? L_WID : L_LEN;
        w_bh = r_orient[r_j][0] ? L_LEN : L_WID;
        w_hit = r_active[r_i] && r_active[r_j] &&
                (w_ax < w_bx + w_bw) && (w_bx < w_ax + w_aw) &&
                (w_ay < w_by + w_bh) && (w_by < w_ay + w_ah);
    end

    always_comb begin
        w_found_nxt = r_acc_found | w_hit;
        w_a_nxt     = r_acc_a;
        w_b_nxt     = r_acc_b;
        if (w_hit && !r_acc_found) begin
            w_a_nxt = r_i;
            w_b_nxt = r_j;
        end
        w_cnt_nxt = r_acc_cnt;
        if (w_hit && (r_acc_cnt != '1)) begin
            w_cnt_nxt = r_acc_cnt + 1'b1;
        end
        w_dirty_nxt = r_acc_dirty | w_wr_ok;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < NUM_CARS; k++) begin
                r_x[k]      <= '0;
                r_y[k]      <= '0;
                r_orient[k] <= '0;
                r_active[k] <= 1'b0;
            end
        end else if (w_wr_ok) begin
            r_x[wr_idx]      <= wr_x;
            r_y[wr_idx]      <= wr_y;
            r_orient[wr_idx] <= wr_orient;
            r_active[wr_idx] <= wr_active;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_i         <= '0;
            r_j         <= '0;
            r_acc_found <= 1'b0;
            r_acc_a     <= '0;
            r_acc_b     <= '0;
            r_acc_cnt   <= '0;
            r_acc_dirty <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_collision <= 1'b0;
            r_hit_a     <= '0;
            r_hit_b     <= '0;
            r_hit_count <= '0;
            r_dirty     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state     <= ST_SCAN;
                        r_busy      <= 1'b1;
                        r_i         <= '0;
                        r_j         <= IDX_W'(1);
                        r_acc_found <= 1'b0;
                        r_acc_a     <= '0;
                        r_acc_b     <= '0;
                        r_acc_cnt   <= '0;
                        r_acc_dirty <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    r_acc_found <= w_found_nxt;
                    r_acc_a     <= w_a_nxt;
                    r_acc_b     <= w_b_nxt;
                    r_acc_cnt   <= w_cnt_nxt;
                    r_acc_dirty <= w_dirty_nxt;
                    if (w_last) begin
                        // Results include the final pair evaluated this cycle.
                        r_state     <= ST_REPORT;
                        r_done      <= 1'b1;
                        r_collision <= w_found_nxt;
                        r_hit_a     <= w_a_nxt;
                        r_hit_b     <= w_b_nxt;
                        r_hit_count <= w_cnt_nxt;
                        r_dirty     <= w_dirty_nxt;
                    end else if (r_j == I_LAST_J) begin
                        r_i <= r_i + 1'b1;
                        r_j <= r_i + IDX_W'(2);
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                ST_REPORT: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign collision = r_collision;
    assign hit_a     = r_hit_a;
    assign hit_b     = r_hit_b;
    assign hit_count = r_hit_count;
    assign dirty     = r_dirty;

endmodule
